cnnip_conv_engine: RTL and testbench
====================================

CNNIP_CONV_ENGINE -- requirements
Module: cnnip_conv_engine

Interface
REQ-001 Parameter IN_BASE, 12'h000, input-memory word address of pixel (0,0).
REQ-002 Parameter W_BASE, 12'h000, weight-memory word address of weight (0,0).
REQ-003 Parameter OUT_BASE, 12'h000, feature-memory word address of output (0,0).
REQ-004 Clock and reset: one clock, clk_a; reset arstz_aq, asynchronous, active-low.
REQ-005 clk_a  in  1  clock; arstz_aq  in  1  async active-low reset.
REQ-006 start  in  1  one-cycle pulse from the controller requesting one convolution pass.
REQ-007 busy  out  1  high from the cycle after start is accepted until done.
REQ-008 done  out  1  one-cycle pulse at pass completion.
REQ-009 in_en/in_addr  out  1/12  input-memory read request, one word per cycle; in_dout/in_valid  in  32/1.
REQ-010 w_en/w_addr  out  1/12  weight-memory read request; w_dout/w_valid  in  32/1.
REQ-011 f_en/f_we/f_addr/f_din  out  1/1/12/32  feature-memory write port.

Function
REQ-012 Geometry fixed: 32x32 input, 5x5 kernel, stride 1, no padding, 28x28 output, row-major addressing.
REQ-013 States: IDLE, LOAD_W, CONV, WRITE, DONE.
REQ-014 IDLE: start=1 moves to LOAD_W; start outside IDLE is ignored.
REQ-015 LOAD_W: issue w_en for 25 consecutive cycles, w_addr = W_BASE+k for k=0..24; capture w_dout[7:0] into weight register k on each w_valid.
REQ-016 LOAD_W exits to CONV on the cycle the 25th w_valid is captured; with 1-cycle memory latency LOAD_W lasts 26 cycles.
REQ-017 CONV for output (r,c): issue in_en for 25 consecutive cycles, in_addr = IN_BASE + (r+kr)*32 + (c+kc), kr outer, kc inner, kr,kc = 0..4.
REQ-018 On each in_valid: acc += sext(in_dout[7:0]) * sext(weight[kr*5+kc]), signed 8x8 multiply, 32-bit signed accumulator; acc is cleared on entry to CONV.
REQ-019 Captures are counted by valid, not by issue; a delayed valid stalls the exit but never drops data. CONV exits to WRITE on the 25th capture.
REQ-020 WRITE, one cycle: f_en=1, f_we=1, f_addr = OUT_BASE + r*28 + c, f_din = acc. Next state is DONE if (r,c)=(27,27); otherwise CONV with c+1, wrapping c 27->0 with r+1.
REQ-021 DONE: done=1 for one cycle, then IDLE; r, c and all counters return to 0.
REQ-022 Latency with 1-cycle memory: done is high in the cycle after the 21194th rising edge following the edge that sampled start (26 + 784*27).
REQ-023 Memory enables are low in every state except the issuing cycles above. f_we is never high without f_en.
REQ-024 Unused upper bits of in_dout and w_dout are ignored.
REQ-025 Weight registers are retained after DONE and reloaded on every start.

Reset
REQ-026 arstz_aq low forces, asynchronously: state IDLE; busy, done, in_en, w_en, f_en and f_we = 0; all addresses, f_din, acc, counters and weight registers = 0.
REQ-027 Reset asserted mid-pass abandons the pass; no done is produced, and a new start after release begins a full pass.

Structure
REQ-028 Package cnnip_pkg holds: the state enum; constants IMG_W=32, K=5, OUT_W=28, ADDR_W=12, DATA_W=32; the 8-bit pixel/weight typedef.
REQ-029 One sub-module, cnnip_mac: signed 8x8 multiply, 32-bit accumulate, with clear and enable inputs.

Verification
REQ-030 All inputs=1, all weights=1, start pulse -> 784 writes, each f_din=25; f_addr 0..783 in order; done exactly once, at the REQ-022 cycle.
REQ-031 Input pixel = (addr mod 256) as signed, weight k=+1 only at k=12 -> output (r,c) = sext(pixel(r+2,c+2)) for all 784 outputs.
REQ-032 All inputs=-128, all weights=-128 -> every f_din=409600; all inputs=127, weights=-128 -> every f_din=-406400.
REQ-033 Memory model delays every 3rd valid by 2 cycles -> results identical to REQ-030, done later, no dropped or extra writes.
REQ-034 start re-pulsed while busy, then arstz_aq pulsed low at output 100 -> no write after reset; a fresh start completes 784 correct writes.
REQ-035 Upper data bits [31:8] randomised -> results unchanged; OUT_BASE=12'h100 -> f_addr spans 0x100..0x40F.

Source files
------------

// File: rtl/cnnip_pkg.sv
// Shared geometry constants, pixel/weight type and controller states for the
// 5x5 convolution engine.
package cnnip_pkg;
  localparam int IMG_W  = 32;
  localparam int K      = 5;
  localparam int OUT_W  = 28;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int NTAPS  = K * K;

  typedef logic signed [7:0] pix_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    CONV,
    WRITE,
    DONE
  } state_e;
endpackage

// File: rtl/cnnip_mac.sv
// Signed 8x8 multiply feeding a 32-bit accumulator; clear takes priority
// over enable.
module cnnip_mac
  import cnnip_pkg::*;
(
  input  logic              clk_a,
  input  logic              arstz_aq,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [7:0]        a_i,
  input  logic [7:0]        b_i,
  output logic [DATA_W-1:0] acc_o
);
  logic signed [15:0]       product;
  logic signed [DATA_W-1:0] acc_q, acc_d;

  always_comb begin
    product = 16'(pix_t'(a_i)) * 16'(pix_t'(b_i));
    acc_d   = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + DATA_W'(product);
    end
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/cnnip_conv_engine.sv
// Direct 5x5 convolution over a 32x32 image: loads 25 weights, then computes
// the 28x28 outputs one at a time, streaming taps from memory per output.
module cnnip_conv_engine
  import cnnip_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IN_BASE  = 12'h000,
  parameter logic [ADDR_W-1:0] W_BASE   = 12'h000,
  parameter logic [ADDR_W-1:0] OUT_BASE = 12'h000
) (
  input  logic              clk_a,
  input  logic              arstz_aq,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              in_en,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_dout,
  input  logic              in_valid,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_dout,
  input  logic              w_valid,
  output logic              f_en,
  output logic              f_we,
  output logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_din
);
  localparam logic [4:0] TAPS     = 5'(NTAPS);
  localparam logic [4:0] LAST_TAP = 5'(NTAPS - 1);
  localparam logic [2:0] LAST_K   = 3'(K - 1);
  localparam logic [4:0] LAST_POS = 5'(OUT_W - 1);

  state_e            state_q, state_d;
  logic [4:0]        issueCnt_q, issueCnt_d;
  logic [4:0]        capCnt_q, capCnt_d;
  logic [2:0]        kr_q, kr_d, kc_q, kc_d;
  logic [4:0]        row_q, row_d, col_q, col_d;
  pix_t              weights_q [NTAPS];
  pix_t              curWeight;
  logic              wCapture, macClear, macEn;
  logic [DATA_W-1:0] acc;
  logic              unusedUpperBits;

  assign unusedUpperBits = ^{in_dout[DATA_W-1:8], w_dout[DATA_W-1:8]};
  // Taps arrive in issue order, so the capture count is also the weight index.
  assign curWeight = weights_q[capCnt_q];

  cnnip_mac u_mac (
    .clk_a    (clk_a),
    .arstz_aq (arstz_aq),
    .clear_i  (macClear),
    .en_i     (macEn),
    .a_i      (in_dout[7:0]),
    .b_i      (curWeight),
    .acc_o    (acc)
  );

  always_comb begin
    state_d    = state_q;
    issueCnt_d = issueCnt_q;
    capCnt_d   = capCnt_q;
    kr_d       = kr_q;
    kc_d       = kc_q;
    row_d      = row_q;
    col_d      = col_q;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    in_en      = 1'b0;
    in_addr    = '0;
    w_en       = 1'b0;
    w_addr     = '0;
    f_en       = 1'b0;
    f_we       = 1'b0;
    f_addr     = '0;
    f_din      = '0;
    wCapture   = 1'b0;
    macClear   = 1'b0;
    macEn      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD_W;
          issueCnt_d = '0;
          capCnt_d   = '0;
        end
      end
      LOAD_W: begin
        if (issueCnt_q < TAPS) begin
          w_en       = 1'b1;
          w_addr     = W_BASE + ADDR_W'(issueCnt_q);
          issueCnt_d = issueCnt_q + 5'd1;
        end
        if (w_valid) begin
          wCapture = 1'b1;
          capCnt_d = capCnt_q + 5'd1;
          if (capCnt_q == LAST_TAP) begin
            state_d    = CONV;
            issueCnt_d = '0;
            capCnt_d   = '0;
            kr_d       = '0;
            kc_d       = '0;
            macClear   = 1'b1;
          end
        end
      end
      CONV: begin
        if (issueCnt_q < TAPS) begin
          in_en      = 1'b1;
          in_addr    = IN_BASE + (ADDR_W'(row_q) + ADDR_W'(kr_q)) * ADDR_W'(IMG_W)
                       + ADDR_W'(col_q) + ADDR_W'(kc_q);
          issueCnt_d = issueCnt_q + 5'd1;
          if (kc_q == LAST_K) begin
            kc_d = '0;
            kr_d = kr_q + 3'd1;
          end else begin
            kc_d = kc_q + 3'd1;
          end
        end
        if (in_valid) begin
          macEn    = 1'b1;
          capCnt_d = capCnt_q + 5'd1;
          if (capCnt_q == LAST_TAP) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        f_en       = 1'b1;
        f_we       = 1'b1;
        f_addr     = OUT_BASE + ADDR_W'(row_q) * ADDR_W'(OUT_W) + ADDR_W'(col_q);
        f_din      = acc;
        issueCnt_d = '0;
        capCnt_d   = '0;
        kr_d       = '0;
        kc_d       = '0;
        if (row_q == LAST_POS && col_q == LAST_POS) begin
          state_d = DONE;
        end else begin
          state_d  = CONV;
          macClear = 1'b1;
          if (col_q == LAST_POS) begin
            col_d = '0;
            row_d = row_q + 5'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_d    = IDLE;
        issueCnt_d = '0;
        capCnt_d   = '0;
        kr_d       = '0;
        kc_d       = '0;
        row_d      = '0;
        col_d      = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      state_q    <= IDLE;
      issueCnt_q <= '0;
      capCnt_q   <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        weights_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      issueCnt_q <= issueCnt_d;
      capCnt_q   <= capCnt_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      row_q      <= row_d;
      col_q      <= col_d;
      if (wCapture) begin
        weights_q[capCnt_q] <= pix_t'(w_dout[7:0]);
      end
    end
  end
endmodule

// File: tb/tb_cnnip_conv_engine.sv
// Self-checking bench for cnnip_conv_engine: table-driven short passes, full
// passes checked against a direct-convolution reference model.
module tb_cnnip_conv_engine;
  import cnnip_pkg::*;

  localparam logic [ADDR_W-1:0] IN_BASE_P  = 12'h200;
  localparam logic [ADDR_W-1:0] W_BASE_P   = 12'h010;
  localparam logic [ADDR_W-1:0] OUT_BASE_P = 12'h100;
  localparam int NOUT = OUT_W * OUT_W;
  // done is seen at the falling edge of the cycle after rising edge 21194,
  // counting the falling edge of the cycle after the start edge as 1.
  localparam int FULL_LAT = 26 + NOUT * 27 + 1;

  logic              clk_a = 1'b0;
  logic              arstz_aq, start;
  logic              busy, done;
  logic              in_en, w_en, f_en, f_we;
  logic [ADDR_W-1:0] in_addr, w_addr, f_addr;
  logic [DATA_W-1:0] in_dout, w_dout, f_din;
  logic              in_valid, w_valid;

  always #5 clk_a = ~clk_a;

  cnnip_conv_engine #(
    .IN_BASE  (IN_BASE_P),
    .W_BASE   (W_BASE_P),
    .OUT_BASE (OUT_BASE_P)
  ) dut (
    .clk_a    (clk_a),
    .arstz_aq (arstz_aq),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .in_en    (in_en),
    .in_addr  (in_addr),
    .in_dout  (in_dout),
    .in_valid (in_valid),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_dout   (w_dout),
    .w_valid  (w_valid),
    .f_en     (f_en),
    .f_we     (f_we),
    .f_addr   (f_addr),
    .f_din    (f_din)
  );

  typedef struct {
    int pixMode;
    int pixVal;
    int wMode;
    int wVal;
    bit useModel;
    int expDin;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    longint            due;
  } resp_t;

  logic [DATA_W-1:0] inMem [4096];
  logic [DATA_W-1:0] wMem  [4096];
  int                expDin [NOUT];
  int                compared = 0;
  int                mismatched = 0;
  int                writeIdx = 0;
  int                doneCount = 0;
  bit                delayMode = 1'b0;
  resp_t             inQ[$];
  resp_t             wQ[$];
  longint            negCycle = 0;
  longint            inLastDue = 0;
  longint            wLastDue = 0;
  int                inResp = 0;
  int                wResp = 0;

  function automatic void checkOutput(input string name, input longint actual,
                                      input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endfunction

  // In-order memory response time: one cycle after the request, never two
  // responses in one cycle, and in delay mode every 3rd response 2 cycles late.
  function automatic longint nextDue(input longint lastDue, input int idx);
    longint d;
    d = (negCycle + 1 > lastDue + 1) ? negCycle + 1 : lastDue + 1;
    if (delayMode && (idx % 3 == 2)) d = d + 2;
    return d;
  endfunction

  // Memory models for the input and weight ports.
  initial begin
    in_valid = 1'b0;
    w_valid  = 1'b0;
    in_dout  = '0;
    w_dout   = '0;
    forever begin
      @(negedge clk_a);
      negCycle++;
      if (!arstz_aq) begin
        inQ.delete();
        wQ.delete();
        inResp    = 0;
        wResp     = 0;
        inLastDue = negCycle;
        wLastDue  = negCycle;
        in_valid  = 1'b0;
        w_valid   = 1'b0;
      end else begin
        if (in_en) begin
          inLastDue = nextDue(inLastDue, inResp);
          inQ.push_back('{inMem[in_addr], inLastDue});
          inResp++;
        end
        if (w_en) begin
          wLastDue = nextDue(wLastDue, wResp);
          wQ.push_back('{wMem[w_addr], wLastDue});
          wResp++;
        end
        if (inQ.size() > 0 && inQ[0].due <= negCycle) begin
          in_valid = 1'b1;
          in_dout  = inQ[0].data;
          void'(inQ.pop_front());
        end else begin
          in_valid = 1'b0;
          in_dout  = $urandom();
        end
        if (wQ.size() > 0 && wQ[0].due <= negCycle) begin
          w_valid = 1'b1;
          w_dout  = wQ[0].data;
          void'(wQ.pop_front());
        end else begin
          w_valid = 1'b0;
          w_dout  = $urandom();
        end
      end
    end
  end

  // Feature-memory write monitor: every write is checked in order.
  initial begin
    forever begin
      @(negedge clk_a);
      if (f_we) checkOutput("f_en with f_we", f_en, 1);
      if (f_en) begin
        checkOutput("f_we with f_en", f_we, 1);
        if (writeIdx < NOUT) begin
          checkOutput($sformatf("f_addr[%0d]", writeIdx), f_addr,
                      longint'(OUT_BASE_P) + writeIdx);
          checkOutput($sformatf("f_din[%0d]", writeIdx), $signed(f_din),
                      expDin[writeIdx]);
        end else begin
          checkOutput("write count bound", writeIdx, NOUT - 1);
        end
        writeIdx++;
      end
      if (done) doneCount++;
    end
  end

  // Fill both memories (random upper bits everywhere) and build expectations.
  task automatic applyStimulus(input vec_t v);
    for (int a = 0; a < 4096; a++) begin
      logic [7:0] low;
      case (v.pixMode)
        0:       low = 8'(v.pixVal);
        1:       low = 8'(a);
        default: low = 8'($urandom());
      endcase
      inMem[a] = {24'($urandom()), low};
      wMem[a]  = $urandom();
    end
    for (int k = 0; k < NTAPS; k++) begin
      logic [7:0] wl;
      case (v.wMode)
        0:       wl = 8'(v.wVal);
        1:       wl = (k == 12) ? 8'd1 : 8'd0;
        default: wl = 8'($urandom());
      endcase
      wMem[int'(W_BASE_P) + k] = {24'($urandom()), wl};
    end
    for (int r = 0; r < OUT_W; r++) begin
      for (int c = 0; c < OUT_W; c++) begin
        int sum;
        sum = 0;
        for (int kr = 0; kr < K; kr++) begin
          for (int kc = 0; kc < K; kc++) begin
            logic [7:0] p, w;
            p = inMem[int'(IN_BASE_P) + (r + kr) * IMG_W + c + kc][7:0];
            w = wMem[int'(W_BASE_P) + kr * K + kc][7:0];
            sum += int'($signed(p)) * int'($signed(w));
          end
        end
        expDin[r * OUT_W + c] = v.useModel ? sum : v.expDin;
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk_a);
    arstz_aq = 1'b0;
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset enables", {in_en, w_en, f_en, f_we}, 0);
    checkOutput("reset addresses", {in_addr, w_addr, f_addr}, 0);
    checkOutput("reset f_din", f_din, 0);
    repeat (3) @(negedge clk_a);
    arstz_aq = 1'b1;
  endtask

  // Start a pass and stop watching once nWrites outputs have been written.
  task automatic runPartial(input int nWrites, input bit rePulse);
    int n;
    writeIdx  = 0;
    doneCount = 0;
    @(negedge clk_a);
    start = 1'b1;
    @(negedge clk_a);
    start = 1'b0;
    n = 1;
    while (writeIdx < nWrites && n < 10000) begin
      if (rePulse) start = (n == 10);
      @(negedge clk_a);
      n++;
    end
    start = 1'b0;
    checkOutput("partial writes reached", writeIdx >= nWrites, 1);
  endtask

  task automatic runFull(input bit exactLatency);
    int n, doneAt;
    writeIdx  = 0;
    doneCount = 0;
    doneAt    = 0;
    @(negedge clk_a);
    checkOutput("busy before start", busy, 0);
    start = 1'b1;
    @(negedge clk_a);
    start = 1'b0;
    n = 1;
    checkOutput("busy after start", busy, 1);
    while (doneAt == 0 && n < 50000) begin
      if (done) begin
        doneAt = n;
      end else begin
        start = (n == 1000);
        @(negedge clk_a);
        n++;
      end
    end
    start = 1'b0;
    checkOutput("done seen", doneAt != 0, 1);
    if (exactLatency) checkOutput("done cycle", doneAt, FULL_LAT);
    else              checkOutput("done later than nominal", doneAt > FULL_LAT, 1);
    repeat (40) @(negedge clk_a);
    checkOutput("write count", writeIdx, NOUT);
    checkOutput("done pulses", doneCount, 1);
    checkOutput("busy after pass", busy, 0);
  endtask

  initial begin
    vec_t vecs [9];
    int   snapshot;
    vecs[0] = '{0,    1, 0,    1, 1'b0,      25};
    vecs[1] = '{0, -128, 0, -128, 1'b0,  409600};
    vecs[2] = '{0,  127, 0, -128, 1'b0, -406400};
    vecs[3] = '{0,   -1, 0,    3, 1'b0,     -75};
    vecs[4] = '{2,    0, 2,    0, 1'b1,       0};
    vecs[5] = '{1,    0, 1,    0, 1'b1,       0};
    vecs[6] = '{1,    0, 1,    0, 1'b1,       0};
    vecs[7] = '{2,    0, 2,    0, 1'b1,       0};
    vecs[8] = '{0,    1, 0,    1, 1'b0,      25};

    arstz_aq = 1'b1;
    start    = 1'b0;
    applyReset();

    $display("[TB] short passes over the vector table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      runPartial(30, 1'b0);
      applyReset();
    end

    $display("[TB] full pass, centre-tap weights, delayed valids");
    delayMode = 1'b1;
    applyStimulus(vecs[6]);
    runFull(1'b0);
    delayMode = 1'b0;

    $display("[TB] start re-pulsed while busy, reset at output 100");
    applyStimulus(vecs[7]);
    runPartial(100, 1'b1);
    applyReset();
    snapshot = writeIdx;
    repeat (300) @(negedge clk_a);
    checkOutput("no write after reset", writeIdx, snapshot);
    checkOutput("no done after reset", doneCount, 0);

    $display("[TB] fresh full pass after reset");
    applyStimulus(vecs[8]);
    runFull(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
